quantum_scheduler: RTL and testbench

QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

---
 rtl/quantum_scheduler.sv | 167 ++++++++++++++++
 tb/tb_quantum_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin preemption timer for an OS scheduler.
//
// A down-counter loaded from a programmable quantum register is decremented on
// every retired instruction. When it expires, the next runnable process slot is
// chosen round-robin. A preemption interrupt is then raised, deferred while a
// disk operation is in flight. The OS acknowledges the interrupt, performs the
// context switch and signals completion, which commits the new PID and reloads
// the counter.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset
//   enable_i        preemption enabled (level)
//   quantum_load_i  one-cycle pulse, writes quantum_in_i into the quantum register
//   quantum_in_i    new quantum in retired instructions
//   instr_done_i    one pulse per retired instruction
//   hd_busy_i       disk operation in flight, defers the interrupt
//   proc_valid_i    bitmap of runnable process slots
//   intr_ack_i      interrupt handler entered (pulse)
//   switch_done_i   context switch finished (pulse)
//   intr_o          preemption interrupt request (registered)
//   cur_pid_o       running slot (registered)
//   next_pid_o      slot selected for the next run (registered)
//   remaining_o     current down-counter value
module quantum_scheduler #(
   parameter int unsigned    QW              = 16,
   parameter int unsigned    NPROC           = 4,
   parameter logic [QW-1:0]  DEFAULT_QUANTUM = QW'(100),
   localparam int unsigned   PW              = (NPROC > 1) ? $clog2(NPROC) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             quantum_load_i,
   input  logic [QW-1:0]    quantum_in_i,
   input  logic             instr_done_i,
   input  logic             hd_busy_i,
   input  logic [NPROC-1:0] proc_valid_i,
   input  logic             intr_ack_i,
   input  logic             switch_done_i,
   output logic             intr_o,
   output logic [PW-1:0]    cur_pid_o,
   output logic [PW-1:0]    next_pid_o,
   output logic [QW-1:0]    remaining_o
);

   typedef enum logic [1:0] {StIdle, StCount, StPend, StSwitch} state_e;

   state_e          state_q;
   logic [QW-1:0]   quantum_q;
   logic [QW-1:0]   remaining_q;
   logic [PW-1:0]   cur_pid_q;
   logic [PW-1:0]   next_pid_q;
   logic            intr_q;
   // Set once next_pid has been chosen for the current expiry.
   logic            sel_done_q;

   logic [QW-1:0]   q_eff;
   logic            rr_found;
   logic [PW-1:0]   rr_pid;
   logic [31:0]     rr_idx;

   // A load coinciding with a reload or IDLE tracking takes effect immediately.
   always_comb begin
      q_eff = quantum_load_i ? quantum_in_i : quantum_q;
   end

   // Round-robin search over the other slots only, starting after cur_pid.
   // rr_found=0 means no slot other than the current one is runnable.
   always_comb begin
      rr_found = 1'b0;
      rr_pid   = cur_pid_q;
      rr_idx   = '0;
      for (int unsigned i = 1; i < NPROC; i++) begin
         rr_idx = 32'(cur_pid_q) + i;
         if (rr_idx >= NPROC) begin
            rr_idx = rr_idx - NPROC;
         end
         if (!rr_found && proc_valid_i[rr_idx[PW-1:0]]) begin
            rr_found = 1'b1;
            rr_pid   = rr_idx[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         quantum_q   <= DEFAULT_QUANTUM;
         remaining_q <= DEFAULT_QUANTUM;
         cur_pid_q   <= '0;
         next_pid_q  <= '0;
         intr_q      <= 1'b0;
         sel_done_q  <= 1'b0;
      end else begin
         if (quantum_load_i) begin
            quantum_q <= quantum_in_i;
         end
         unique case (state_q)
            StIdle: begin
               intr_q      <= 1'b0;
               sel_done_q  <= 1'b0;
               remaining_q <= q_eff;
               if (enable_i && (q_eff != '0)) begin
                  state_q <= StCount;
               end
            end
            StCount: begin
               if (!enable_i) begin
                  state_q <= StIdle;
                  intr_q  <= 1'b0;
               end else if (instr_done_i) begin
                  if (remaining_q <= QW'(1)) begin
                     remaining_q <= '0;
                     sel_done_q  <= 1'b0;
                     state_q     <= StPend;
                  end else begin
                     remaining_q <= remaining_q - QW'(1);
                  end
               end
            end
            StPend: begin
               if (!enable_i) begin
                  state_q    <= StIdle;
                  intr_q     <= 1'b0;
                  sel_done_q <= 1'b0;
               end else if (!sel_done_q) begin
                  // First PEND cycle: proc_valid is sampled here and only here.
                  if (rr_found) begin
                     next_pid_q <= rr_pid;
                     sel_done_q <= 1'b1;
                  end else begin
                     // Nobody else to run: restart the quantum silently.
                     next_pid_q  <= cur_pid_q;
                     remaining_q <= q_eff;
                     state_q     <= (q_eff != '0) ? StCount : StIdle;
                  end
               end else if (intr_q) begin
                  if (intr_ack_i) begin
                     intr_q     <= 1'b0;
                     sel_done_q <= 1'b0;
                     state_q    <= StSwitch;
                  end
               end else if (!hd_busy_i) begin
                  intr_q <= 1'b1;
               end
            end
            StSwitch: begin
               if (switch_done_i) begin
                  cur_pid_q   <= next_pid_q;
                  remaining_q <= q_eff;
                  state_q     <= (enable_i && (q_eff != '0)) ? StCount : StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign intr_o      = intr_q;
   assign cur_pid_o   = cur_pid_q;
   assign next_pid_o  = next_pid_q;
   assign remaining_o = remaining_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
module tb_quantum_scheduler;

   localparam int NPROC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        quantum_load;
   logic [15:0] quantum_in;
   logic        instr_done;
   logic        hd_busy;
   logic [3:0]  proc_valid;
   logic        intr_ack;
   logic        switch_done;
   logic        intr;
   logic [1:0]  cur_pid;
   logic [1:0]  next_pid;
   logic [15:0] remaining;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   quantum_scheduler dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .quantum_load_i (quantum_load),
      .quantum_in_i   (quantum_in),
      .instr_done_i   (instr_done),
      .hd_busy_i      (hd_busy),
      .proc_valid_i   (proc_valid),
      .intr_ack_i     (intr_ack),
      .switch_done_i  (switch_done),
      .intr_o         (intr),
      .cur_pid_o      (cur_pid),
      .next_pid_o     (next_pid),
      .remaining_o    (remaining)
   );

   // Behavioural model: counting flag, an "age since expiry" (-1 = not expired)
   // and a switching flag describe where the scheduler is.
   int m_q = 100;
   int m_rem = 100;
   int m_cur = 0;
   int m_next = 0;
   int m_intr = 0;
   int m_counting = 0;
   int m_age = -1;
   int m_swapping = 0;

   function automatic int pick_other(int cur, logic [3:0] pv);
      for (int k = 1; k < NPROC; k++) begin
         if (pv[(cur + k) % NPROC]) return (cur + k) % NPROC;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_q = 100; m_rem = 100; m_cur = 0; m_next = 0; m_intr = 0;
      m_counting = 0; m_age = -1; m_swapping = 0;
   endtask

   task automatic model_edge();
      int qe;
      int other;
      qe = quantum_load ? int'(quantum_in) : m_q;
      if (quantum_load) m_q = int'(quantum_in);
      if (m_swapping != 0) begin
         if (switch_done) begin
            m_cur = m_next;
            m_rem = qe;
            m_swapping = 0;
            m_counting = (enable && qe != 0) ? 1 : 0;
         end
      end else if (m_age >= 0) begin
         if (!enable) begin
            m_age = -1; m_intr = 0; m_counting = 0;
         end else if (m_age == 0) begin
            other = pick_other(m_cur, proc_valid);
            if (other < 0) begin
               m_next = m_cur; m_rem = qe; m_age = -1;
               m_counting = (qe != 0) ? 1 : 0;
            end else begin
               m_next = other; m_age = 1;
            end
         end else if (m_intr != 0) begin
            if (intr_ack) begin
               m_intr = 0; m_age = -1; m_swapping = 1;
            end
         end else if (!hd_busy) begin
            m_intr = 1;
         end
      end else if (m_counting != 0) begin
         if (!enable) m_counting = 0;
         else if (instr_done) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_age = 0;
         end
      end else begin
         m_rem = qe; m_intr = 0;
         if (enable && qe != 0) m_counting = 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_edge();
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("cyc_intr", 32'(intr), 32'(m_intr));
         check("cyc_cur_pid", 32'(cur_pid), 32'(m_cur));
         check("cyc_next_pid", 32'(next_pid), 32'(m_next));
         check("cyc_remaining", 32'(remaining), 32'(m_rem));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(int n);
      instr_done = 1'b1;
      repeat (n) tick();
      instr_done = 1'b0;
   endtask

   task automatic ack_and_switch();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      switch_done = 1'b1;
      tick();
      switch_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0; quantum_load = 1'b0; quantum_in = '0; instr_done = 1'b0;
      hd_busy = 1'b0; proc_valid = '0; intr_ack = 1'b0; switch_done = 1'b0;
      #3;
      check("rst_intr", 32'(intr), 0);
      check("rst_cur", 32'(cur_pid), 0);
      check("rst_next", 32'(next_pid), 0);
      check("rst_remaining", 32'(remaining), 100);
      tick();
      rst = 1'b0;

      // Basic preemption: quantum 3, slots 0 and 1 runnable.
      quantum_load = 1'b1; quantum_in = 16'd3; proc_valid = 4'b0011;
      tick();
      quantum_load = 1'b0;
      check("idle_track", 32'(remaining), 3);
      enable = 1'b1;
      tick();
      retire(3);
      check("basic_zero", 32'(remaining), 0);
      tick();
      check("basic_intr_lat1", 32'(intr), 0);
      tick();
      check("basic_intr_lat2", 32'(intr), 1);
      check("basic_next", 32'(next_pid), 1);
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      check("basic_ack_clr", 32'(intr), 0);
      retire(1);
      check("switch_ignores_instr", 32'(remaining), 0);
      switch_done = 1'b1;
      tick();
      switch_done = 1'b0;
      check("basic_cur", 32'(cur_pid), 1);
      check("basic_reload", 32'(remaining), 3);

      // Disk deferral: cur=1 wraps to slot 0.
      hd_busy = 1'b1;
      retire(3);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hd_defer_intr", 32'(intr), 0);
      end
      check("hd_next", 32'(next_pid), 0);
      hd_busy = 1'b0;
      tick();
      check("hd_release_intr", 32'(intr), 1);
      ack_and_switch();
      check("hd_cur", 32'(cur_pid), 0);

      // Reach slot 3, then wrap-around with late proc_valid change ignored.
      proc_valid = 4'b1000;
      retire(3);
      tick(); tick();
      check("to3_next", 32'(next_pid), 3);
      ack_and_switch();
      check("to3_cur", 32'(cur_pid), 3);
      proc_valid = 4'b1010;
      retire(3);
      tick();
      proc_valid = 4'b0100;
      tick();
      check("wrap_intr", 32'(intr), 1);
      check("wrap_next", 32'(next_pid), 1);
      ack_and_switch();
      check("wrap_cur", 32'(cur_pid), 1);

      // Load during COUNT, then single runnable slot.
      retire(1);
      quantum_load = 1'b1; quantum_in = 16'd5;
      tick();
      quantum_load = 1'b0;
      check("load_keeps_count", 32'(remaining), 2);
      proc_valid = 4'b0010;
      retire(2);
      tick();
      check("single_reload5", 32'(remaining), 5);
      check("single_next", 32'(next_pid), 1);
      quantum_load = 1'b1; quantum_in = 16'd2;
      tick();
      quantum_load = 1'b0;
      retire(5);
      tick();
      check("single_reload2", 32'(remaining), 2);
      check("single_intr", 32'(intr), 0);
      retire(2);
      quantum_load = 1'b1; quantum_in = 16'd7;
      tick();
      quantum_load = 1'b0;
      check("reload_uses_in", 32'(remaining), 7);
      check("single_cur", 32'(cur_pid), 1);

      // Disable while PEND with intr raised.
      proc_valid = 4'b0011;
      retire(7);
      tick(); tick();
      check("pend_intr", 32'(intr), 1);
      enable = 1'b0;
      tick();
      check("disable_intr", 32'(intr), 0);
      tick();
      check("disable_idle_track", 32'(remaining), 7);
      check("disable_cur", 32'(cur_pid), 1);

      // Zero quantum keeps the block idle.
      quantum_load = 1'b1; quantum_in = 16'd0;
      tick();
      quantum_load = 1'b0;
      enable = 1'b1;
      retire(3);
      check("zero_q_rem", 32'(remaining), 0);
      check("zero_q_intr", 32'(intr), 0);

      // Async reset in the middle of SWITCH.
      quantum_load = 1'b1; quantum_in = 16'd2;
      tick();
      quantum_load = 1'b0;
      retire(2);
      tick(); tick();
      check("pre_rst_intr", 32'(intr), 1);
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_intr", 32'(intr), 0);
      check("async_cur", 32'(cur_pid), 0);
      check("async_next", 32'(next_pid), 0);
      check("async_rem", 32'(remaining), 100);
      tick();
      rst = 1'b0;
      // Stray acknowledge and switch_done are ignored after reset.
      intr_ack = 1'b1; switch_done = 1'b1;
      tick();
      intr_ack = 1'b0; switch_done = 1'b0;
      retire(5);
      check("post_rst_rem", 32'(remaining), 95);
      check("post_rst_intr", 32'(intr), 0);
      check("post_rst_cur", 32'(cur_pid), 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
